// File: rtl/lagartoII_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// register count and the requester index used by the writeback arbiter.
package lagartoII_pkg;

  localparam int unsigned DATAW_DEF = 32;
  localparam int unsigned ADDRW_DEF = 5;
  localparam int unsigned NREGS_DEF = 2 ** ADDRW_DEF;

  // Writeback requesters; the value doubles as the last-grant register encoding.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  // Round-robin pick between the two writeback requesters. A lone requester
  // always wins; under contention the one not granted last time wins. With no
  // requester the result is irrelevant and ALU is returned.
  function automatic req_e rr_pick(input logic alu_valid, input logic lsu_valid,
                                   input req_e last_grant);
    req_e pick;
    if (alu_valid && lsu_valid) begin
      pick = (last_grant == REQ_ALU) ? REQ_LSU : REQ_ALU;
    end else if (lsu_valid) begin
      pick = REQ_LSU;
    end else begin
      pick = REQ_ALU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request channel: one requester (ALU or load unit) presenting a
// destination register and result to the writeback arbiter.
interface rf_wb_arbiter_if
  import lagartoII_pkg::*;
#(
  parameter int unsigned DATAW = DATAW_DEF,
  parameter int unsigned ADDRW = ADDRW_DEF
);

  logic             valid;
  logic             ready;
  logic [ADDRW-1:0] rd;
  logic [DATAW-1:0] data;

  // Requester side: holds valid/rd/data stable until it sees ready at an edge.
  modport master (
    output valid,
    output rd,
    output data,
    input  ready
  );

  // Arbiter side.
  modport slave (
    input  valid,
    input  rd,
    input  data,
    output ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard. The issue stage marks a destination
// busy; the committed register-file write clears it. A set wins over a clear
// of the same register in the same cycle, and register 0 is never busy.
module rf_scoreboard
  import lagartoII_pkg::*;
#(
  parameter int unsigned ADDRW = ADDRW_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_i,
  input  logic [ADDRW-1:0]      set_idx_i,
  input  logic                  clr_i,
  input  logic [ADDRW-1:0]      clr_idx_i,
  output logic [(2**ADDRW)-1:0] busy_o
);

  logic [(2**ADDRW)-1:0] busy_q;
  logic [(2**ADDRW)-1:0] busy_d;

  // Next-state: apply clear first so a same-register set overrides it.
  always_comb begin
    // NOTE: start from the held value so every path assigns busy_d; no latch.
    busy_d = busy_q;
    if (clr_i) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_i && (set_idx_i != '0)) begin
      busy_d[set_idx_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State register for the busy vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: this is control state, not data storage, so every bit is reset;
      // a stale busy bit after reset would stall issue forever.
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking so all flops sample pre-edge values together.
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter. Two requesters (ALU and load unit) share the
// single register-file write port. A combinational round-robin grant accepts
// at most one request per cycle; the accepted write is driven onto the write
// port one cycle later from a single registered stage that never stalls.
// Writes to x0 are accepted but suppressed. A scoreboard tracks registers with
// an outstanding write between issue and commit.
module rf_wb_arbiter
  import lagartoII_pkg::*;
#(
  parameter int unsigned DATAW = DATAW_DEF,
  parameter int unsigned ADDRW = ADDRW_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rf_wb_arbiter_if.slave        alu_wb,
  rf_wb_arbiter_if.slave        lsu_wb,
  input  logic                  iss_valid_i,
  input  logic [ADDRW-1:0]      iss_rd_i,
  output logic                  we_o,
  output logic [ADDRW-1:0]      addrd_o,
  output logic [DATAW-1:0]      datard_o,
  output logic [(2**ADDRW)-1:0] busy_o
);

  req_e             grant;
  req_e             last_grant_q;
  req_e             last_grant_d;
  logic             any_valid;
  logic             xfer;
  logic [ADDRW-1:0] sel_rd;
  logic [DATAW-1:0] sel_data;

  logic             we_q;
  logic             we_d;
  logic [ADDRW-1:0] addrd_q;
  logic [ADDRW-1:0] addrd_d;
  logic [DATAW-1:0] datard_q;
  logic [DATAW-1:0] datard_d;

  // Grant and ready. Ready is qualified only by "some requester is valid" so
  // both readies are low when idle; otherwise exactly one ready is high and it
  // is selected by the round-robin pick, not by the requester's own valid.
  always_comb begin
    any_valid    = alu_wb.valid | lsu_wb.valid;
    grant        = rr_pick(alu_wb.valid, lsu_wb.valid, last_grant_q);
    alu_wb.ready = any_valid && (grant == REQ_ALU);
    lsu_wb.ready = any_valid && (grant == REQ_LSU);
    xfer         = (alu_wb.valid && alu_wb.ready) || (lsu_wb.valid && lsu_wb.ready);
    sel_rd       = (grant == REQ_LSU) ? lsu_wb.rd   : alu_wb.rd;
    sel_data     = (grant == REQ_LSU) ? lsu_wb.data : alu_wb.data;
  end

  // Output-stage and last-grant next state. Address and data only move on a
  // transfer and otherwise hold; a transfer to x0 leaves the write enable low.
  always_comb begin
    we_d         = xfer && (sel_rd != '0);
    addrd_d      = addrd_q;
    datard_d     = datard_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      addrd_d      = sel_rd;
      datard_d     = sel_data;
      last_grant_d = grant;
    end
  end

  // Write-port stage and round-robin state. Reset drops any in-flight write
  // and leaves last grant at LSU so the ALU wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q         <= 1'b0;
      addrd_q      <= '0;
      datard_q     <= '0;
      last_grant_q <= REQ_LSU;
    end else begin
      we_q         <= we_d;
      addrd_q      <= addrd_d;
      datard_q     <= datard_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign we_o     = we_q;
  assign addrd_o  = addrd_q;
  assign datard_o = datard_q;

  // The clear fires on the edge that commits the write into the register file.
  rf_scoreboard #(
    .ADDRW (ADDRW)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .set_i     (iss_valid_i),
    .set_idx_i (iss_rd_i),
    .clr_i     (we_q),
    .clr_idx_i (addrd_q),
    .busy_o    (busy_o)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset behaviour, single-requester writes,
// round-robin contention, x0 suppression, scoreboard set/clear and mid-cycle
// reset. Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_rf_wb_arbiter;
  import lagartoII_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          we;
  logic [AW-1:0] addrd;
  logic [DW-1:0] datard;
  logic [31:0]   busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.DATAW(DW), .ADDRW(AW)) alu_if ();
  rf_wb_arbiter_if #(.DATAW(DW), .ADDRW(AW)) lsu_if ();

  rf_wb_arbiter #(
    .DATAW (DW),
    .ADDRW (AW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .alu_wb      (alu_if),
    .lsu_wb      (lsu_if),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .we_o        (we),
    .addrd_o     (addrd),
    .datard_o    (datard),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_if.valid = 1'b0;
    lsu_if.valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    alu_if.valid = 1'b1;
    alu_if.rd    = rd;
    alu_if.data  = data;
  endtask

  task automatic drive_lsu(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    lsu_if.valid = 1'b1;
    lsu_if.rd    = rd;
    lsu_if.data  = data;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    alu_if.rd = '0;  alu_if.data = '0;
    lsu_if.rd = '0;  lsu_if.data = '0;
    idle();

    // Reset values, ready follows valid during reset, transfer ignored.
    #2;
    chk("rst_we",     64'(we),     64'h0);
    chk("rst_addrd",  64'(addrd),  64'h0);
    chk("rst_datard", 64'(datard), 64'h0);
    chk("rst_busy",   64'(busy),   64'h0);
    drive_alu(5'd3, 32'hDEADBEEF);
    #1;
    chk("rst_alu_ready", 64'(alu_if.ready), 64'h1);
    #3;                              // past the edge at t=5, still in reset
    chk("rst_xfer_ignored", 64'(we), 64'h0);
    idle();
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_we",  64'(we),           64'h0);
    chk("idle_alu_rdy", 64'(alu_if.ready), 64'h0);
    chk("idle_lsu_rdy", 64'(lsu_if.ready), 64'h0);

    // ALU only: rd=5.
    drive_alu(5'd5, 32'hAAAAAAAA);
    #1;
    chk("alu_only_alu_rdy", 64'(alu_if.ready), 64'h1);
    chk("alu_only_lsu_rdy", 64'(lsu_if.ready), 64'h0);
    step();
    idle();
    chk("alu_only_we",    64'(we),     64'h1);
    chk("alu_only_addrd", 64'(addrd),  64'h5);
    chk("alu_only_data",  64'(datard), 64'hAAAAAAAA);
    step();
    chk("alu_only_we_off",  64'(we),     64'h0);
    chk("alu_only_addr_hd", 64'(addrd),  64'h5);
    chk("alu_only_data_hd", 64'(datard), 64'hAAAAAAAA);

    // Contention after reset: ALU, LSU, ALU, LSU.
    pulse_reset();
    drive_alu(5'd6, 32'h11111111);
    drive_lsu(5'd7, 32'h22222222);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d_alu_rdy", i), 64'(alu_if.ready), (i % 2 == 0) ? 64'h1 : 64'h0);
      chk($sformatf("rr%0d_lsu_rdy", i), 64'(lsu_if.ready), (i % 2 == 0) ? 64'h0 : 64'h1);
      step();
      chk($sformatf("rr%0d_we", i),    64'(we),     64'h1);
      chk($sformatf("rr%0d_addrd", i), 64'(addrd),  (i % 2 == 0) ? 64'h6 : 64'h7);
      chk($sformatf("rr%0d_data", i),  64'(datard), (i % 2 == 0) ? 64'h11111111 : 64'h22222222);
    end
    idle();
    step();
    chk("rr_end_we",   64'(we),   64'h0);
    chk("rr_end_busy", 64'(busy), 64'h0);

    // LSU write to x0: accepted, not written.
    drive_lsu(5'd0, 32'hFFFFFFFF);
    #1;
    chk("x0_lsu_rdy", 64'(lsu_if.ready), 64'h1);
    chk("x0_alu_rdy", 64'(alu_if.ready), 64'h0);
    step();
    idle();
    chk("x0_we",   64'(we),   64'h0);
    chk("x0_busy", 64'(busy), 64'h0);

    // Scoreboard: issue rd=7, write it back a few cycles later.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    step();
    iss_valid = 1'b0;
    chk("sb_set",   64'(busy), 64'h80);
    step();
    chk("sb_hold1", 64'(busy), 64'h80);
    step();
    chk("sb_hold2", 64'(busy), 64'h80);
    drive_alu(5'd7, 32'h77777777);
    step();
    idle();
    chk("sb_we",      64'(we),    64'h1);
    chk("sb_we_addr", 64'(addrd), 64'h7);
    chk("sb_hold3",   64'(busy),  64'h80);
    step();
    chk("sb_clear",   64'(busy),  64'h0);
    chk("sb_we_off",  64'(we),    64'h0);

    // Set and clear of rd=7 on the same edge: stays set.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    step();
    iss_valid = 1'b0;
    drive_alu(5'd7, 32'h12345678);
    step();
    idle();
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    chk("sc_we", 64'(we), 64'h1);
    step();
    iss_valid = 1'b0;
    chk("sc_set_wins", 64'(busy), 64'h80);
    drive_alu(5'd7, 32'h0BADF00D);
    step();
    idle();
    step();
    chk("sc_cleared", 64'(busy), 64'h0);

    // Issue to x0 never marks busy.
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    step();
    iss_valid = 1'b0;
    chk("iss_x0_busy", 64'(busy), 64'h0);

    // Reset mid-cycle after a transfer: write and scoreboard discarded.
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    step();
    iss_valid = 1'b0;
    chk("mr_busy_set", 64'(busy), 64'h200);
    drive_alu(5'd9, 32'h99999999);
    step();
    idle();
    chk("mr_we_before", 64'(we), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_we_async",   64'(we),     64'h0);
    chk("mr_busy_async", 64'(busy),   64'h0);
    chk("mr_addr_async", 64'(addrd),  64'h0);
    chk("mr_data_async", 64'(datard), 64'h0);
    #2;
    rst_n = 1'b1;
    step();
    chk("mr_no_write1", 64'(we),   64'h0);
    chk("mr_busy_post", 64'(busy), 64'h0);
    step();
    chk("mr_no_write2", 64'(we),   64'h0);

    // Last grant was ALU before reset; reset returns it to LSU so ALU wins.
    drive_alu(5'd1, 32'h1);
    drive_lsu(5'd2, 32'h2);
    #1;
    chk("mr_rr_alu_rdy", 64'(alu_if.ready), 64'h1);
    chk("mr_rr_lsu_rdy", 64'(lsu_if.ready), 64'h0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
